sd_cmd_rx: RTL and testbench

Serial receiver and checker for 48-bit SD-style command/response frames on the CMD line. It is the receive-side counterpart of the team's CRC-7 transmit path. Once armed, it waits a bounded number of bit strobes for a start bit, then deserializes the frame and recomputes CRC-7 (x^7 + x^3 + 1) over the first 40 bits. It reports index, argument, CRC status and end-bit status to the command controller, or a timeout if no start bit arrives.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/crc7_lfsr.sv | 29 ++
 rtl/sd_cmd_rx.sv | 162 ++++++++++++++++
 tb/tb_sd_cmd_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line frame path: frame geometry,
// CRC-7 polynomial, receive FSM encoding and the CRC-7 single-bit step.
package sd_pkg;

    localparam int FRAME_LEN = 48;
    localparam int CRC_SPAN  = 40;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2
    } rx_state_t;

    // One bit of CRC-7 (x^7 + x^3 + 1), MSB-first serial data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bitval);
        logic inv;
        inv = bitval ^ crc[6];
        return {crc[5:0], 1'b0} ^ (inv ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_lfsr.sv
// Serial CRC-7 generator shared by the transmit and receive CMD paths so
// both ends compute bit-identical checksums. Clear wins over Enable.
module crc7_lfsr
    import sd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       Clear,
    input  logic       Enable,
    input  logic       BITVAL,
    output logic [6:0] CRC
);

    logic [6:0] crc_reg;

    // CRC register: clear, or advance by one bit on each enabled strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_reg <= 7'h00;
        end else if (Clear) begin
            crc_reg <= 7'h00;
        end else if (Enable) begin
            crc_reg <= crc7_step(crc_reg, BITVAL);
        end
    end

    assign CRC = crc_reg;

endmodule

// File: rtl/sd_cmd_rx.sv
// SD CMD-line frame receiver: waits a bounded number of strobes for a start
// bit, deserializes a 48-bit frame, checks CRC-7 over the first 40 bits and
// the end bit, and reports the decoded fields with a one-cycle Done pulse.
module sd_cmd_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Enable,
    input  logic        BITVAL,
    input  logic        Arm,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic        Dir,
    output logic [5:0]  Index,
    output logic [31:0] Arg,
    output logic        CrcErr,
    output logic        EndErr
);

    rx_state_t   state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [47:0] shreg_reg, shreg_next;
    logic        done_reg, done_next;
    logic        timeout_reg, timeout_next;
    logic        dir_reg, dir_next;
    logic [5:0]  index_reg, index_next;
    logic [31:0] arg_reg, arg_next;
    logic        crcerr_reg, crcerr_next;
    logic        enderr_reg, enderr_next;

    logic        crc_clear;
    logic        crc_en;
    logic [6:0]  crc_val;
    logic [47:0] frame_full;
    logic        unused_start_bit;

    // The complete frame as it stands once the end bit is sampled.
    assign frame_full = {shreg_reg[46:0], BITVAL};
    // The start bit is zero by construction, so it carries no information.
    assign unused_start_bit = frame_full[47];

    crc7_lfsr u_crc (
        .CLK    (CLK),
        .RST    (RST),
        .Clear  (crc_clear),
        .Enable (crc_en),
        .BITVAL (BITVAL),
        .CRC    (crc_val)
    );

    // State, counters, shift register and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 8'd0;
            bit_cnt_reg  <= 6'd0;
            shreg_reg    <= 48'd0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            dir_reg      <= 1'b0;
            index_reg    <= 6'd0;
            arg_reg      <= 32'd0;
            crcerr_reg   <= 1'b0;
            enderr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            dir_reg      <= dir_next;
            index_reg    <= index_next;
            arg_reg      <= arg_next;
            crcerr_reg   <= crcerr_next;
            enderr_reg   <= enderr_next;
        end
    end

    // Next-state logic: strobe handling first, then Arm overrides the state
    // so a completing frame or timeout still pulses while re-arming.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;
        done_next     = 1'b0;
        timeout_next  = 1'b0;
        dir_next      = dir_reg;
        index_next    = index_reg;
        arg_next      = arg_reg;
        crcerr_next   = crcerr_reg;
        enderr_next   = enderr_reg;
        crc_clear     = 1'b0;
        crc_en        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Strobes are ignored until armed.
            end
            ST_WAIT_START: begin
                if (Enable) begin
                    if (!BITVAL) begin
                        // Start bit: shifting a 0 into a cleared CRC leaves it 0.
                        state_next   = ST_RECV;
                        bit_cnt_next = 6'd1;
                        shreg_next   = {shreg_reg[46:0], BITVAL};
                        crc_en       = 1'b1;
                    end else if (wait_cnt_reg == 8'(NCR_MAX - 1)) begin
                        timeout_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
            end
            ST_RECV: begin
                if (Enable) begin
                    shreg_next   = {shreg_reg[46:0], BITVAL};
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    crc_en       = (bit_cnt_reg <= 6'(CRC_SPAN - 1));
                    if (bit_cnt_reg == 6'(FRAME_LEN - 1)) begin
                        dir_next     = frame_full[46];
                        index_next   = frame_full[45:40];
                        arg_next     = frame_full[39:8];
                        crcerr_next  = (frame_full[7:1] != crc_val);
                        enderr_next  = ~BITVAL;
                        done_next    = 1'b1;
                        state_next   = ST_IDLE;
                        bit_cnt_next = 6'd0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (Arm) begin
            state_next    = ST_WAIT_START;
            wait_cnt_next = 8'd0;
            bit_cnt_next  = 6'd0;
            shreg_next    = 48'd0;
            crc_clear     = 1'b1;
        end
    end

    assign Busy    = (state_reg != ST_IDLE);
    assign Done    = done_reg;
    assign Timeout = timeout_reg;
    assign Dir     = dir_reg;
    assign Index   = index_reg;
    assign Arg     = arg_reg;
    assign CrcErr  = crcerr_reg;
    assign EndErr  = enderr_reg;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Self-checking bench for sd_cmd_rx: table of frames plus hand-written
// timeout, abort, re-arm and reset sequences, checked through a scoreboard.
module tb_sd_cmd_rx;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Enable;
    logic        BITVAL;
    logic        Arm;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic        Dir;
    logic [5:0]  Index;
    logic [31:0] Arg;
    logic        CrcErr;
    logic        EndErr;

    sd_cmd_rx #(.NCR_MAX(64)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Enable  (Enable),
        .BITVAL  (BITVAL),
        .Arm     (Arm),
        .Busy    (Busy),
        .Done    (Done),
        .Timeout (Timeout),
        .Dir     (Dir),
        .Index   (Index),
        .Arg     (Arg),
        .CrcErr  (CrcErr),
        .EndErr  (EndErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [47:0] frame;
        int          period;
        int          lead;
        logic        dir;
        logic [5:0]  index;
        logic [31:0] arg;
        logic        crcerr;
        logic        enderr;
    } vec_t;

    typedef struct {
        string       name;
        bit          is_timeout;
        logic        dir;
        logic [5:0]  index;
        logic [31:0] arg;
        logic        crcerr;
        logic        enderr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_tmo = 0;
    bit prev_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Independent CRC-7 reference, MSB first.
    function automatic logic [6:0] crc7_of(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c = {c[5], c[4], c[3], c[2] ^ fb, c[1], c[0], fb};
        end
        return c;
    endfunction

    function automatic vec_t mk(input string nm, input logic [47:0] f, input int per, input int ld,
                                input logic d, input logic [5:0] ix, input logic [31:0] a,
                                input logic ce, input logic ee);
        vec_t v;
        v.name = nm; v.frame = f; v.period = per; v.lead = ld;
        v.dir = d; v.index = ix; v.arg = a; v.crcerr = ce; v.enderr = ee;
        return v;
    endfunction

    function automatic exp_t frame_exp(input vec_t v);
        exp_t e;
        e.name = v.name; e.is_timeout = 1'b0;
        e.dir = v.dir; e.index = v.index; e.arg = v.arg;
        e.crcerr = v.crcerr; e.enderr = v.enderr;
        return e;
    endfunction

    function automatic exp_t tmo_exp(input string nm);
        exp_t e;
        e.name = nm; e.is_timeout = 1'b1;
        e.dir = 1'b0; e.index = 6'd0; e.arg = 32'd0; e.crcerr = 1'b0; e.enderr = 1'b0;
        return e;
    endfunction

    // Output monitor: pops the scoreboard on every Done/Timeout pulse.
    always @(negedge CLK) begin
        if (Done) n_done++;
        if (Timeout) n_tmo++;
        if (Done) check("done_single_cycle", {63'd0, prev_done}, 64'd0);
        prev_done = Done;
        if (Done || Timeout) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got Done=%0b Timeout=%0b want no pulse", Done, Timeout);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, ".kind"}, {62'd0, Done, Timeout},
                      mon_e.is_timeout ? 64'd1 : 64'd2);
                if (mon_e.is_timeout) begin
                    $display("txn %s: timeout busy=%0b", mon_e.name, Busy);
                end else begin
                    check({mon_e.name, ".dir"}, {63'd0, Dir}, {63'd0, mon_e.dir});
                    check({mon_e.name, ".index"}, {58'd0, Index}, {58'd0, mon_e.index});
                    check({mon_e.name, ".arg"}, {32'd0, Arg}, {32'd0, mon_e.arg});
                    check({mon_e.name, ".crcerr"}, {63'd0, CrcErr}, {63'd0, mon_e.crcerr});
                    check({mon_e.name, ".enderr"}, {63'd0, EndErr}, {63'd0, mon_e.enderr});
                    $display("txn %s: dir=%0b index=%0d arg=%08h crcerr=%0b enderr=%0b",
                             mon_e.name, Dir, Index, Arg, CrcErr, EndErr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic strobe(input logic b, input int period);
        BITVAL = b;
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        BITVAL = 1'b1;
        repeat (period - 1) tick();
    endtask

    task automatic arm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] f, input int from, input int to_, input int period);
        for (int i = from; i >= to_; i--) strobe(f[i], period);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check({nm, ".pending"}, 64'(sb.size()), 64'd0);
    endtask

    logic [47:0] cmd0;
    logic [47:0] cmd8;
    logic [39:0] body;
    int          done_before;

    initial begin
        RST = 1'b1; Enable = 1'b0; BITVAL = 1'b1; Arm = 1'b0;
        cmd0 = 48'h40_0000_0000_95;
        cmd8 = 48'h48_0000_01AA_87;

        vecs[0] = mk("cmd0",         cmd0,                 1, 0, 1'b1, 6'd0, 32'h0,        1'b0, 1'b0);
        vecs[1] = mk("cmd8_every3",  cmd8,                 3, 2, 1'b1, 6'd8, 32'h0000_01AA, 1'b0, 1'b0);
        vecs[2] = mk("cmd8_argflip", 48'h48_0000_01AB_87,  1, 1, 1'b1, 6'd8, 32'h0000_01AB, 1'b1, 1'b0);
        vecs[3] = mk("cmd0_badend",  48'h40_0000_0000_94,  1, 0, 1'b1, 6'd0, 32'h0,        1'b0, 1'b1);
        body = 40'h51_1234_5678;
        vecs[4] = mk("cmd17",        {body, crc7_of(body), 1'b1}, 2, 5, 1'b1, 6'd17, 32'h1234_5678, 1'b0, 1'b0);
        body = 40'h11_0000_0900;
        vecs[5] = mk("r1_dir0",      {body, crc7_of(body), 1'b1}, 1, 10, 1'b0, 6'd17, 32'h0000_0900, 1'b0, 1'b0);
        vecs[6] = mk("cmd8_botherr", 48'h48_0000_01AA_84,  1, 0, 1'b1, 6'd8, 32'h0000_01AA, 1'b1, 1'b1);

        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        check("reset_outputs", {21'd0, Busy, Done, Timeout, Dir, Index, Arg, CrcErr, EndErr}, 64'd0);

        // Strobes in IDLE must not start anything.
        repeat (3) strobe(1'b0, 1);
        check("idle_ignores_enable", {63'd0, Busy}, 64'd0);

        // Table-driven frames.
        for (int k = 0; k < 7; k++) begin
            arm();
            sb.push_back(frame_exp(vecs[k]));
            repeat (vecs[k].lead) strobe(1'b1, vecs[k].period);
            send_bits(vecs[k].frame, 47, 0, vecs[k].period);
            wait_drain(vecs[k].name);
        end

        // Timeout at strobe 64; status fields from the last frame persist.
        arm();
        sb.push_back(tmo_exp("timeout64"));
        repeat (63) strobe(1'b1, 1);
        check("tmo.busy_at_63", {63'd0, Busy}, 64'd1);
        check("tmo.no_pulse_at_63", {63'd0, Timeout}, 64'd0);
        strobe(1'b1, 1);
        check("tmo.pulse_at_64", {63'd0, Timeout}, 64'd1);
        check("tmo.busy_fell", {63'd0, Busy}, 64'd0);
        tick();
        check("tmo.pulse_one_cycle", {63'd0, Timeout}, 64'd0);
        check("tmo.index_held", {58'd0, Index}, 64'd8);
        wait_drain("timeout64");

        // Start bit on strobe 63 is still accepted.
        arm();
        sb.push_back(frame_exp(vecs[0]));
        repeat (62) strobe(1'b1, 1);
        send_bits(cmd0, 47, 0, 1);
        wait_drain("start_at_63");

        // Abort: partial CMD8, re-arm, full CMD0 -> exactly one Done.
        done_before = n_done;
        arm();
        sb.push_back(frame_exp(vecs[0]));
        send_bits(cmd8, 47, 27, 1);
        arm();
        send_bits(cmd0, 47, 0, 1);
        wait_drain("abort");
        check("abort.done_count", 64'(n_done - done_before), 64'd1);

        // Arm on the final strobe: Done still pulses and the receiver stays armed.
        arm();
        sb.push_back(frame_exp(vecs[1]));
        send_bits(cmd8, 47, 1, 1);
        BITVAL = cmd8[0];
        Enable = 1'b1;
        Arm = 1'b1;
        tick();
        Enable = 1'b0;
        Arm = 1'b0;
        check("rearm.done", {63'd0, Done}, 64'd1);
        check("rearm.busy", {63'd0, Busy}, 64'd1);
        sb.push_back(frame_exp(vecs[4]));
        send_bits(vecs[4].frame, 47, 0, 1);
        wait_drain("rearm_next");

        // Asynchronous reset mid-frame clears every output at once.
        arm();
        send_bits(cmd8, 47, 20, 1);
        #1;
        RST = 1'b1;
        #1;
        check("rst_mid.outputs", {21'd0, Busy, Done, Timeout, Dir, Index, Arg, CrcErr, EndErr}, 64'd0);
        tick();
        tick();
        RST = 1'b0;
        arm();
        sb.push_back(frame_exp(vecs[0]));
        send_bits(cmd0, 47, 0, 1);
        wait_drain("after_reset");
        check("timeout_count", 64'(n_tmo), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
